// File: rtl/planificador_salida.sv
// Weighted round-robin egress scheduler: pops four blue FIFOs onto one
// registered valid/ready output, giving each port up to peso+1 back-to-back grants.
module planificador_salida #(
    parameter int DATA_W = 12,
    parameter int W_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Enable,
    input  logic [3:0]            FIFO_empty,
    input  logic [DATA_W-1:0]     data_in_p0,
    input  logic [DATA_W-1:0]     data_in_p1,
    input  logic [DATA_W-1:0]     data_in_p2,
    input  logic [DATA_W-1:0]     data_in_p3,
    input  logic [4*W_BITS-1:0]   pesos,
    input  logic                  load_pesos,
    input  logic                  out_ready,
    output logic [3:0]            Pop,
    output logic [DATA_W-1:0]     data_out,
    output logic                  valid_out,
    output logic [1:0]            port_out,
    output logic                  idle
);

    localparam int CW = W_BITS + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, SERVE = 1'b1} state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [1:0]           ptr_r;
    logic [CW-1:0]        credit_r;
    logic                 fresh_r;
    logic                 pend_r;
    logic [1:0]           pend_port_r;
    logic [4*W_BITS-1:0]  pesos_r;

    logic [1:0]           grant_s;
    logic [1:0]           base_s;
    logic [1:0]           cand_s;
    logic                 switch_s;
    logic                 found_s;
    logic                 any_s;
    logic                 can_issue_s;
    logic                 capture_s;
    logic [DATA_W-1:0]    sel_data_s;
    logic [W_BITS-1:0]    peso_g_s;

    function automatic logic [W_BITS-1:0] peso_of(input logic [4*W_BITS-1:0] w,
                                                   input logic [1:0] p);
        peso_of = w[p*W_BITS +: W_BITS];
    endfunction

    assign any_s    = ~&FIFO_empty;
    assign peso_g_s = peso_of(pesos_r, grant_s);

    // Grant selection: keep the current port while it has credit, else scan onward.
    always_comb begin
        grant_s  = ptr_r;
        switch_s = 1'b0;
        found_s  = 1'b0;
        cand_s   = ptr_r;
        // Right after reset the scan must begin at p0 itself, not at ptr+1.
        base_s   = fresh_r ? (ptr_r - 2'd1) : ptr_r;
        if ((credit_r != {CW{1'b0}}) && !FIFO_empty[ptr_r]) begin
            found_s = 1'b1;
        end else begin
            switch_s = 1'b1;
            for (int i = 1; i <= 4; i++) begin
                cand_s = base_s + 2'(i);
                if (!found_s && !FIFO_empty[cand_s]) begin
                    grant_s = cand_s;
                    found_s = 1'b1;
                end else begin
                    grant_s = grant_s;
                end
            end
        end
    end

    // Pop issue: a pending word must always have a slot to land in next cycle.
    always_comb begin
        can_issue_s = Enable && (state_r == SERVE) && found_s
                      && (!valid_out || out_ready)
                      && !(pend_r && valid_out && !out_ready)
                      && (!pend_r || out_ready);
        capture_s   = pend_r && (!valid_out || out_ready);
        if (can_issue_s) begin
            Pop = 4'b0001 << grant_s;
        end else begin
            Pop = 4'b0000;
        end
    end

    // Source mux for the word popped in the previous cycle.
    always_comb begin
        case (pend_port_r)
            2'd0:    sel_data_s = data_in_p0;
            2'd1:    sel_data_s = data_in_p1;
            2'd2:    sel_data_s = data_in_p2;
            2'd3:    sel_data_s = data_in_p3;
            default: sel_data_s = {DATA_W{1'b0}};
        endcase
    end

    // Next-state logic; Enable=0 freezes the FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (Enable && any_s) state_next_s = SERVE;
                else                 state_next_s = IDLE;
            end
            SERVE: begin
                if (Enable && !any_s && !pend_r && !valid_out) state_next_s = IDLE;
                else                                           state_next_s = SERVE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Scheduler state: FSM, pointer, credit, weights and the pending-pop marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            ptr_r       <= 2'd0;
            credit_r    <= {CW{1'b0}};
            fresh_r     <= 1'b1;
            pend_r      <= 1'b0;
            pend_port_r <= 2'd0;
            pesos_r     <= {(4*W_BITS){1'b0}};
        end else begin
            state_r <= state_next_s;
            if (load_pesos) begin
                pesos_r <= pesos;
            end
            if (can_issue_s) begin
                pend_r      <= 1'b1;
                pend_port_r <= grant_s;
                fresh_r     <= 1'b0;
                // Reload is peso+1, minus the pop made in this same cycle.
                if (switch_s) begin
                    ptr_r    <= grant_s;
                    credit_r <= {1'b0, peso_g_s};
                end else begin
                    credit_r <= credit_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end else if (capture_s) begin
                pend_r <= 1'b0;
            end
        end
    end

    // Output slot: capture the popped word, clear on acceptance, hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= {DATA_W{1'b0}};
            port_out  <= 2'd0;
            valid_out <= 1'b0;
        end else if (capture_s) begin
            data_out  <= sel_data_s;
            port_out  <= pend_port_r;
            valid_out <= 1'b1;
        end else if (valid_out && out_ready) begin
            valid_out <= 1'b0;
        end
    end

    assign idle = (state_r == IDLE) && !pend_r && !valid_out;

endmodule
